// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
//
// Generic inter-stage pipeline register with a valid / allow-in handshake,
// a flush, NOP presentation of empty slots and a saturating stall counter.
// It sits between fetch/decode, decode/execute, execute/memory and
// memory/writeback.
//
// Optional feature macro: PIPE_SKID_EN
//   defined   : a second (skid) entry S sits behind the main entry M. The
//               stage holds up to two entries, and allow_in_o is a registered
//               function of S.valid, so it has no combinational path from
//               out_allow_in_i.
//   undefined : a single entry. allow_in_o = ~M.valid | out_allow_in_i.
//
// Parameters
//   DATA_W     payload width in bits
//   NOP_VALUE  payload presented while the slot is empty or flushed
//   CNT_W      stall counter width
//
// Ports
//   clk_i            in   clock; all state updates on the rising edge
//   rst_n            in   asynchronous active-low reset
//   flush_i          in   discard every held entry
//   in_valid_i       in   upstream holds a valid entry
//   in_data_i        in   upstream payload
//   allow_in_o       out  stage can accept an entry this cycle
//   out_valid_o      out  output entry valid
//   out_data_o       out  output payload; NOP_VALUE whenever out_valid_o=0
//   out_allow_in_i   in   downstream accepts this cycle
//   stall_cnt_clr_i  in   synchronous clear of the stall counter
//   stall_cnt_o      out  saturating count of downstream-stall cycles
// -----------------------------------------------------------------------------
module pipe_stage_reg #(
  parameter int unsigned       DATA_W    = 64,
  parameter logic [DATA_W-1:0] NOP_VALUE = {DATA_W{1'b0}},
  parameter int unsigned       CNT_W     = 16
) (
  input  logic              clk_i,
  input  logic              rst_n,
  input  logic              flush_i,
  input  logic              in_valid_i,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              allow_in_o,
  output logic              out_valid_o,
  output logic [DATA_W-1:0] out_data_o,
  input  logic              out_allow_in_i,
  input  logic              stall_cnt_clr_i,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Main entry M: always the oldest entry, drives the output directly.
  logic              m_valid_q;
  logic              m_valid_d;
  logic [DATA_W-1:0] m_data_q;
  logic [DATA_W-1:0] m_data_d;

  // Stall counter.
  logic [CNT_W-1:0]  stall_cnt_q;
  logic [CNT_W-1:0]  stall_cnt_d;

  // M leaves the stage this cycle.
  logic              issue;
  // M is valid but downstream refuses it.
  logic              stall;

  assign issue = m_valid_q & out_allow_in_i;
  assign stall = m_valid_q & ~out_allow_in_i;

`ifdef PIPE_SKID_EN
  // ---------------------------------------------------------------------------
  // Two-entry variant: M plus skid entry S (S is always younger than M).
  // ---------------------------------------------------------------------------
  logic              s_valid_q;
  logic              s_valid_d;
  logic [DATA_W-1:0] s_data_q;
  logic [DATA_W-1:0] s_data_d;

  // Purely a flop output: the upstream ready path is cut here.
  assign allow_in_o = ~s_valid_q;

  always_comb begin
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    s_valid_d = s_valid_q;
    s_data_d  = s_data_q;

    if (flush_i) begin
      // Kill everything, including an entry presented this cycle.
      m_valid_d = 1'b0;
      m_data_d  = NOP_VALUE;
      s_valid_d = 1'b0;
      s_data_d  = NOP_VALUE;
    end else if (!s_valid_q) begin
      if (!m_valid_q || issue) begin
        // M is free next cycle: load the incoming entry or a bubble.
        m_valid_d = in_valid_i;
        m_data_d  = in_valid_i ? in_data_i : NOP_VALUE;
      end else if (in_valid_i) begin
        // M is stuck; allow_in_o was still high, so park the entry in S.
        s_valid_d = 1'b1;
        s_data_d  = in_data_i;
      end
    end else if (issue) begin
      // S moves forward into M; allow_in_o rises next cycle.
      m_valid_d = 1'b1;
      m_data_d  = s_data_q;
      s_valid_d = 1'b0;
      s_data_d  = NOP_VALUE;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      s_valid_q <= 1'b0;
      s_data_q  <= NOP_VALUE;
    end else begin
      s_valid_q <= s_valid_d;
      s_data_q  <= s_data_d;
    end
  end

`else
  // ---------------------------------------------------------------------------
  // Single-entry variant: ready passes straight through from downstream.
  // ---------------------------------------------------------------------------
  assign allow_in_o = ~m_valid_q | out_allow_in_i;

  always_comb begin
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;

    if (flush_i) begin
      m_valid_d = 1'b0;
      m_data_d  = NOP_VALUE;
    end else if (allow_in_o) begin
      // Either empty or issuing: take the new entry or fall back to a bubble.
      m_valid_d = in_valid_i;
      m_data_d  = in_valid_i ? in_data_i : NOP_VALUE;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Main entry register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      m_valid_q <= 1'b0;
      m_data_q  <= NOP_VALUE;
    end else begin
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
    end
  end

  // M's payload is forced to NOP_VALUE whenever it goes invalid, so it can
  // drive the output without an extra mux.
  assign out_valid_o = m_valid_q;
  assign out_data_o  = m_data_q;

  // ---------------------------------------------------------------------------
  // Stall counter: clear beats increment; flush has no effect on it.
  // ---------------------------------------------------------------------------
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_cnt_clr_i) begin
      stall_cnt_d = '0;
    end else if (stall && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_reg
//
// Directed bench for pipe_stage_reg. Works in both configurations: the
// expectations that differ are selected with PIPE_SKID_EN. Inputs change 1 ns
// after the rising edge; outputs are checked after that, well away from it.
// -----------------------------------------------------------------------------
module tb_pipe_stage_reg;

  localparam int          DW  = 64;
  localparam int          CW  = 4;
  localparam logic [63:0] NOP = 64'hDEAD_BEEF_0000_0000;

`ifdef PIPE_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic          clk_i           = 1'b0;
  logic          rst_n           = 1'b0;
  logic          flush_i         = 1'b0;
  logic          in_valid_i      = 1'b0;
  logic [DW-1:0] in_data_i       = '0;
  logic          allow_in_o;
  logic          out_valid_o;
  logic [DW-1:0] out_data_o;
  logic          out_allow_in_i  = 1'b0;
  logic          stall_cnt_clr_i = 1'b0;
  logic [CW-1:0] stall_cnt_o;

  int checks = 0;
  int errors = 0;

  pipe_stage_reg #(
    .DATA_W    (DW),
    .NOP_VALUE (NOP),
    .CNT_W     (CW)
  ) dut (
    .clk_i           (clk_i),
    .rst_n           (rst_n),
    .flush_i         (flush_i),
    .in_valid_i      (in_valid_i),
    .in_data_i       (in_data_i),
    .allow_in_o      (allow_in_o),
    .out_valid_o     (out_valid_o),
    .out_data_o      (out_data_o),
    .out_allow_in_i  (out_allow_in_i),
    .stall_cnt_clr_i (stall_cnt_clr_i),
    .stall_cnt_o     (stall_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) begin
      $display("%0t check %s obs=%0h exp=%0h", $time, tag, obs, exp);
    end else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Watchdog: the sequence is fixed-length, this only guards against a hang.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [63:0] items [3];
    int          cur;
    logic        acc;

    items[0] = 64'h0000_0000_0000_00A0;
    items[1] = 64'h0000_0000_0000_00B0;
    items[2] = 64'h0000_0000_0000_00C0;

    // ---------------- reset ----------------
    tick();
    tick();
    chk("rst_valid", 64'(out_valid_o), 64'd0);
    chk("rst_data",  out_data_o,       NOP);
    chk("rst_cnt",   64'(stall_cnt_o), 64'd0);
    chk("rst_allow", 64'(allow_in_o),  64'd1);
    rst_n = 1'b1;
    tick();

    // Mid-stream reset: load an entry, stall once, then reset asynchronously.
    in_valid_i     = 1'b1;
    in_data_i      = 64'h55;
    out_allow_in_i = 1'b0;
    tick();
    in_valid_i = 1'b0;
    chk("mid_valid", 64'(out_valid_o), 64'd1);
    chk("mid_data",  out_data_o,       64'h55);
    tick();
    chk("mid_cnt",   64'(stall_cnt_o), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 64'(out_valid_o), 64'd0);
    chk("arst_data",  out_data_o,       NOP);
    chk("arst_cnt",   64'(stall_cnt_o), 64'd0);
    chk("arst_allow", 64'(allow_in_o),  64'd1);
    #2;
    rst_n = 1'b1;
    tick();

    // ---------------- streaming 1..8 ----------------
    out_allow_in_i = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid_i = 1'b1;
      in_data_i  = 64'(i);
      #1;
      chk($sformatf("str_allow%0d", i), 64'(allow_in_o), 64'd1);
      tick();
      chk($sformatf("str_valid%0d", i), 64'(out_valid_o), 64'd1);
      chk($sformatf("str_data%0d", i),  out_data_o,       64'(i));
    end
    in_valid_i = 1'b0;
    tick();
    chk("str_end_valid", 64'(out_valid_o), 64'd0);
    chk("str_end_data",  out_data_o,       NOP);
    chk("str_cnt",       64'(stall_cnt_o), 64'd0);

    // ---------------- stall A, B, C ----------------
    cur            = 0;
    out_allow_in_i = 1'b0;
    in_valid_i     = 1'b1;
    in_data_i      = items[0];
    #1;
    chk("stl_allow0", 64'(allow_in_o), 64'd1);
    tick();
    cur = 1;
    for (int k = 1; k <= 3; k++) begin
      in_data_i = items[cur];
      #1;
      // With skid the first stall cycle still accepts B into S.
      chk($sformatf("stl_allow%0d", k), 64'(allow_in_o), (SKID && k == 1) ? 64'd1 : 64'd0);
      acc = allow_in_o;
      tick();
      if (acc) cur++;
      chk($sformatf("stl_valid%0d", k), 64'(out_valid_o), 64'd1);
      chk($sformatf("stl_data%0d", k),  out_data_o,       items[0]);
      chk($sformatf("stl_cnt%0d", k),   64'(stall_cnt_o), 64'(k));
    end
    // Release: A issues now.
    out_allow_in_i = 1'b1;
    in_data_i      = items[cur];
    #1;
    chk("rel_allow4", 64'(allow_in_o), SKID ? 64'd0 : 64'd1);
    acc = allow_in_o;
    tick();
    if (acc) cur++;
    chk("rel_dataB", out_data_o,       items[1]);
    chk("rel_cnt",   64'(stall_cnt_o), 64'd3);
    in_data_i = items[cur];
    #1;
    chk("rel_allow5", 64'(allow_in_o), 64'd1);
    tick();
    chk("rel_dataC",  out_data_o,        items[2]);
    chk("rel_validC", 64'(out_valid_o),  64'd1);
    in_valid_i = 1'b0;
    tick();
    chk("rel_end_valid", 64'(out_valid_o), 64'd0);

    // ---------------- flush ----------------
    out_allow_in_i = 1'b0;
    in_valid_i     = 1'b1;
    in_data_i      = 64'hE0;
    tick();
    if (SKID) begin
      in_data_i = 64'hF0;
      tick();
    end
    flush_i   = 1'b1;
    in_data_i = 64'hD0;
    tick();
    flush_i        = 1'b0;
    in_valid_i     = 1'b0;
    out_allow_in_i = 1'b1;
    #1;
    chk("fl_valid", 64'(out_valid_o), 64'd0);
    chk("fl_data",  out_data_o,       NOP);
    chk("fl_allow", 64'(allow_in_o),  64'd1);
    chk("fl_cnt",   64'(stall_cnt_o), SKID ? 64'd5 : 64'd4);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("fl_after_valid%0d", k), 64'(out_valid_o), 64'd0);
    end

    // ---------------- counter saturation and clear ----------------
    stall_cnt_clr_i = 1'b1;
    tick();
    stall_cnt_clr_i = 1'b0;
    chk("cnt_clr0", 64'(stall_cnt_o), 64'd0);
    out_allow_in_i = 1'b0;
    in_valid_i     = 1'b1;
    in_data_i      = 64'h60;
    tick();
    in_valid_i = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      chk($sformatf("cnt_sat%0d", k), 64'(stall_cnt_o), (k > 15) ? 64'd15 : 64'(k));
    end
    stall_cnt_clr_i = 1'b1;
    tick();
    stall_cnt_clr_i = 1'b0;
    chk("cnt_clr1", 64'(stall_cnt_o), 64'd0);
    tick();
    chk("cnt_res1", 64'(stall_cnt_o), 64'd1);
    tick();
    chk("cnt_res2", 64'(stall_cnt_o), 64'd2);
    chk("cnt_held", out_data_o,       64'h60);
    out_allow_in_i = 1'b1;
    tick();
    chk("cnt_final",   64'(stall_cnt_o), 64'd2);
    chk("cnt_drained", 64'(out_valid_o), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Generic, parametrised inter-stage pipeline register for the multi-cycle-issue CPU pipeline. It is used between fetch/decode, decode/execute, execute/memory and memory/writeback. It carries an opaque payload bus with a valid/allow-in handshake and a flush. Empty slots are presented as a configurable NOP payload. An optional skid entry registers the upstream allow-in path, and a saturating stall counter supports performance analysis.

## Interface
Parameters:
- DATA_W, 64: payload width in bits (concatenated stage fields).
- NOP_VALUE, {DATA_W{1'b0}}: payload driven when the slot is empty or flushed (encodes nop PC/nPC/commit/instr fields).
- CNT_W, 16: stall counter width.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush_i  in  1  discard every held entry (mispredict/trap kill).
- in_valid_i  in  1  upstream holds a valid entry.
- in_data_i  in  DATA_W  upstream payload.
- allow_in_o  out  1  stage can accept an entry this cycle.
- out_valid_o  out  1  output entry valid.
- out_data_o  out  DATA_W  output payload; equals NOP_VALUE whenever out_valid_o=0.
- out_allow_in_i  in  1  downstream accepts this cycle.
- stall_cnt_clr_i  in  1  synchronous clear of the stall counter.
- stall_cnt_o  out  CNT_W  saturating count of downstream-stall cycles.

## Operation
- Accept = in_valid_i & allow_in_o. Issue = out_valid_o & out_allow_in_i.
- Main entry M drives out_valid_o/out_data_o. The skid entry S exists only with the macro.
- Without skid:
  - allow_in_o = ~M.valid | out_allow_in_i (combinational).
  - When allow_in_o=1: M.valid <= in_valid_i; M.data <= in_valid_i ? in_data_i : NOP_VALUE.
  - Otherwise M holds.
- With skid:
  - allow_in_o = ~S.valid (registered, no combinational path from out_allow_in_i).
  - S empty, and M empty or issuing: M <= incoming entry, or bubble if in_valid_i=0.
  - S empty, M full and not issuing, in_valid_i=1: S <= incoming entry.
  - S full and M issuing: M <= S; S empties.
  - S full and M not issuing: hold both.
  - Order is always preserved (M older than S).
- Flush:
  - Highest priority. Next state: M and S invalid, payloads NOP_VALUE.
  - An entry presented in the flush cycle is dropped even if allow_in_o=1.
  - An issue in the flush cycle still completes downstream.
- Stall counter:
  - Increments when out_valid_o & ~out_allow_in_i.
  - Saturates at 2^CNT_W-1.
  - stall_cnt_clr_i wins over increment.
  - Flush does not affect the counter.
- Reset values:
  - out_valid_o=0, out_data_o=NOP_VALUE, stall_cnt_o=0.
  - allow_in_o=1 in both configurations.
  - S.valid=0.

## Timing
- Latency: accepted entry appears on out_valid_o/out_data_o the cycle after acceptance (1 cycle).
- Entry routed through S: appears on the output the cycle after the M issue that frees M.
- Throughput: one entry per cycle with downstream continuously ready.
- With skid, stall propagation: the first stall cycle still accepts one entry into S. allow_in_o drops the following cycle. It rises the cycle after M issues with S full.
- Asynchronous reset assertion clears state immediately, mid-transfer included. An in-flight entry is lost. Deassertion is synchronised externally.

## Configuration
- PIPE_SKID_EN:
  - Defined: the S entry is instantiated and allow_in_o is a registered function of S.valid. The stage holds up to 2 entries.
  - Undefined: single entry; allow_in_o is combinational from out_allow_in_i, as in the existing stage registers.

## Test plan
- Reset: hold rst_n=0 mid-stream, then release -> out_valid_o=0, out_data_o=NOP_VALUE, stall_cnt_o=0, allow_in_o=1.
- Streaming: DATA_W=64; present values 1..8 back-to-back, out_allow_in_i=1 -> outputs 1..8 on consecutive cycles, each 1 cycle after acceptance, no gaps.
- Stall with skid (PIPE_SKID_EN):
  - Feed A, B, C with out_allow_in_i=0 for 3 cycles -> A held in M, B captured in S, allow_in_o=0 from the next cycle, C not accepted.
  - On release -> output order A, B, C.
  - stall_cnt_o=3.
- Stall without skid: same stimulus -> allow_in_o=0 in the same cycle as the stall, only A held, then A, B, C in order.
- Flush: M and S full, flush_i=1 with in_valid_i=1 (data D) -> next cycle out_valid_o=0, out_data_o=NOP_VALUE, D never appears, allow_in_o=1.
- Counter: CNT_W=4; stall 20 cycles -> stall_cnt_o saturates at 15. Assert stall_cnt_clr_i during the stall -> stall_cnt_o=0 the next cycle, then it resumes counting.
